flag_unit: RTL and testbench

Parametrised processor status-flag unit with a hardware save/restore stack. It holds six registered flags: carry, overflow, half-carry, zero, sign and parity. Arithmetic and result flags update under separate enables. The whole flag word can be pushed to or popped from an internal LIFO of configurable depth, for interrupt entry/exit and flag-save instructions. It sits between the ALU result path and the control unit, and the control unit reads the flags for conditional branches.

---
 rtl/flag_unit.sv | 82 ++++++++
 tb/tb_flag_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// flag_unit: six registered status flags {ac,pf,sf,zf,ov,cy} with a LIFO save/restore stack.
module flag_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce_arith,
   input  logic             cy_new,
   input  logic             ov_new,
   input  logic             ac_new,
   input  logic             ce_res,
   input  logic [WIDTH-1:0] res,
   input  logic             ld,
   input  logic [5:0]       ld_data,
   input  logic             push,
   input  logic             pop,
   input  logic             err_clr,
   output logic             cy,
   output logic             ov,
   output logic             ac,
   output logic             zf,
   output logic             sf,
   output logic             pf,
   output logic [5:0]       flags,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             stk_err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [5:0] F_RST = 6'h14;

   logic [5:0]    f_q, f_d, f_u;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [5:0]    stk_q [DEPTH];
   logic          push_ok, pop_ok, ovf, unf;
   logic [AW-1:0] wr_idx, rd_idx;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   // Simultaneous push and pop cancel out entirely.
   assign push_ok = push & ~pop & ~full;
   assign pop_ok  = pop & ~push & ~empty;
   assign ovf     = push & ~pop & full;
   assign unf     = pop & ~push & empty;
   assign wr_idx  = AW'(cnt_q);
   assign rd_idx  = AW'(cnt_q - CW'(1));

   always_comb begin
      f_u = f_q;
      if (ce_arith) {f_u[5], f_u[1], f_u[0]} = {ac_new, ov_new, cy_new};
      if (ce_res) f_u[4:2] = {~^res, res[WIDTH-1], ~|res};
      f_d   = pop_ok ? stk_q[rd_idx] : ld ? ld_data : f_u;
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
      err_d = (ovf | unf) ? 1'b1 : err_clr ? 1'b0 : err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_q   <= F_RST;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         f_q   <= f_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Stack storage is not reset; entries at or above count are never read.
   always_ff @(posedge clk) begin
      if (push_ok) stk_q[wr_idx] <= f_q;
   end

   assign flags   = f_q;
   assign {ac, pf, sf, zf, ov, cy} = f_q;
   assign count   = cnt_q;
   assign stk_err = err_q;
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed checks of flag updates, priorities, stack and async reset.
module tb_flag_unit;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce_arith = 0, cy_new = 0, ov_new = 0, ac_new = 0, ce_res = 0;
   logic [7:0] res = '0;
   logic       ld = 0, push = 0, pop = 0, err_clr = 0;
   logic [5:0] ld_data = '0;
   logic       cy, ov, ac, zf, sf, pf, empty, full, stk_err;
   logic [5:0] flags;
   logic [2:0] count;
   int         checks = 0, failures = 0;

   flag_unit #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .ce_arith(ce_arith), .cy_new(cy_new), .ov_new(ov_new),
      .ac_new(ac_new), .ce_res(ce_res), .res(res), .ld(ld), .ld_data(ld_data),
      .push(push), .pop(pop), .err_clr(err_clr), .cy(cy), .ov(ov), .ac(ac),
      .zf(zf), .sf(sf), .pf(pf), .flags(flags), .count(count), .empty(empty),
      .full(full), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      {ce_arith, cy_new, ov_new, ac_new, ce_res, ld, push, pop, err_clr} = '0;
      res = '0;
      ld_data = '0;
   endtask

   initial begin
      #12 rst = 1'b0;
      #1;
      chk("rst_flags", {2'b0, flags}, 8'h14);
      chk("rst_count", {5'b0, count}, 8'd0);
      chk("rst_empty_full_err", {5'b0, empty, full, stk_err}, 8'b100);
      ce_res = 1; res = 8'h00; tick();
      chk("res00_zsp", {5'b0, zf, sf, pf}, 8'b101);
      ce_res = 1; res = 8'h81; tick();
      chk("res81_zsp", {5'b0, zf, sf, pf}, 8'b011);
      ce_res = 1; res = 8'h07; tick();
      chk("res07_zsp", {5'b0, zf, sf, pf}, 8'b000);
      ce_res = 1; res = 8'h00; tick();
      ce_arith = 1; cy_new = 1; ov_new = 1; ac_new = 0; tick();
      chk("arith_flags", {2'b0, flags}, 8'h17);
      ld = 1; ld_data = 6'h2A; ce_arith = 1; ce_res = 1; res = 8'h80; tick();
      chk("ld_over_update", {2'b0, flags}, 8'h2A);
      // Fill the stack with 1,2,4,8.
      for (int i = 0; i < 4; i++) begin
         ld = 1; ld_data = 6'(1 << i); tick();
         push = 1; tick();
         chk("push_holds_f", {2'b0, flags}, 8'(1 << i));
      end
      chk("full_count", {5'b0, count}, 8'd4);
      chk("full_flags", {6'b0, empty, full}, 8'b01);
      chk("no_err_yet", {7'b0, stk_err}, 8'd0);
      push = 1; tick();
      chk("ovf_err", {7'b0, stk_err}, 8'd1);
      chk("ovf_count", {5'b0, count}, 8'd4);
      err_clr = 1; tick();
      chk("err_clr", {7'b0, stk_err}, 8'd0);
      for (int i = 3; i >= 0; i--) begin
         pop = 1; ld = 1; ld_data = 6'h3F; tick();
         chk("pop_order", {2'b0, flags}, 8'(1 << i));
         chk("pop_count", {5'b0, count}, 8'(i));
      end
      chk("empty_after_pops", {6'b0, empty, full}, 8'b10);
      pop = 1; tick();
      chk("unf_err", {7'b0, stk_err}, 8'd1);
      chk("unf_f_unchanged", {2'b0, flags}, 8'h01);
      err_clr = 1; tick();
      chk("unf_clr", {7'b0, stk_err}, 8'd0);
      err_clr = 1; pop = 1; tick();
      chk("set_beats_clr", {7'b0, stk_err}, 8'd1);
      err_clr = 1; tick();
      ld = 1; ld_data = 6'h00; tick();
      push = 1; ce_arith = 1; cy_new = 1; tick();
      chk("push_upd_f", {2'b0, flags}, 8'h01);
      chk("push_upd_count", {5'b0, count}, 8'd1);
      pop = 1; tick();
      chk("pop_pre_update", {2'b0, flags}, 8'h00);
      ld = 1; ld_data = 6'h3F; tick();
      push = 1; tick();
      ld = 1; ld_data = 6'h2A; tick();
      push = 1; tick();
      push = 1; pop = 1; ld = 1; ld_data = 6'h15; tick();
      chk("pushpop_count", {5'b0, count}, 8'd2);
      chk("pushpop_err", {7'b0, stk_err}, 8'd0);
      chk("pushpop_ld", {2'b0, flags}, 8'h15);
      pop = 1; tick();
      chk("pushpop_stack_kept", {2'b0, flags}, 8'h2A);
      push = 1; tick();
      push = 1; tick();
      ld = 1; ld_data = 6'h3F; tick();
      chk("pre_rst_count", {5'b0, count}, 8'd3);
      chk("pre_rst_flags", {2'b0, flags}, 8'h3F);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_flags", {2'b0, flags}, 8'h14);
      chk("async_rst_count", {5'b0, count}, 8'd0);
      chk("async_rst_empty", {6'b0, empty, full}, 8'b10);
      @(negedge clk);
      rst = 1'b0;
      #1;
      pop = 1; tick();
      chk("post_rst_unf", {7'b0, stk_err}, 8'd1);
      chk("post_rst_f", {2'b0, flags}, 8'h14);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
